// File: rtl/spi_master_ctrl.sv
// SPI master engine: one CMD_W+DATA_W frame per start, all CPOL/CPHA modes, programmable SCLK.
// Optional macro SPI_LOOPBACK_EN adds a loopback input that routes registered mosi to the sampler.
module spi_master_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CMD_W  = 2,
  parameter int unsigned NUM_CS = 1,
  parameter int unsigned DIV_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CMD_W+DATA_W-1:0] data_in,
  input  logic [2:0]              cs_sel,
  input  logic [DIV_W-1:0]        clk_div,
  input  logic                    cpol,
  input  logic                    cpha,
`ifdef SPI_LOOPBACK_EN
  input  logic                    loopback,
`endif
  output logic [DATA_W-1:0]       data_out,
  output logic                    busy,
  output logic                    done,
  output logic                    sclk,
  output logic                    mosi,
  input  logic                    miso,
  output logic [NUM_CS-1:0]       ss_n
);

  localparam int unsigned F    = CMD_W + DATA_W;
  localparam int unsigned HP_W = $clog2(2 * F);
  localparam logic [HP_W-1:0] LastHp = HP_W'(2 * F - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StXfer, StHold, StDone} state_e;

  state_e            state_q;
  logic [DIV_W-1:0]  div_q, cnt_q;
  logic [HP_W-1:0]   hp_q, hp_next;
  logic [F-1:0]      tx_q;
  logic [DATA_W-1:0] rx_q;
  logic              cpha_q;
  logic [NUM_CS-1:0] cs_onehot;
  logic              cs_valid, miso_s, half_end, sample_now;

  always_comb begin
    cs_onehot = '0;
    for (int unsigned i = 0; i < NUM_CS; i++) cs_onehot[i] = (32'(cs_sel) == i);
  end

  assign cs_valid = (32'(cs_sel) < NUM_CS);

`ifdef SPI_LOOPBACK_EN
  assign miso_s = loopback ? mosi : miso;
`else
  assign miso_s = miso;
`endif

  assign half_end = (cnt_q == div_q);
  // Index of the half-period that begins at the next boundary; even = leading edge.
  assign hp_next    = (state_q == StSetup) ? '0 : hp_q + HP_W'(1);
  assign sample_now = (hp_next[0] == cpha_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      div_q    <= '0;
      cnt_q    <= '0;
      hp_q     <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      cpha_q   <= 1'b0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      ss_n     <= '1;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && cs_valid) begin
            state_q <= StSetup;
            busy    <= 1'b1;
            cnt_q   <= '0;
            hp_q    <= '0;
            div_q   <= clk_div;
            cpha_q  <= cpha;
            sclk    <= cpol;
            ss_n    <= ~cs_onehot;
            if (!cpha) begin
              mosi <= data_in[F-1];
              tx_q <= data_in << 1;
            end else begin
              tx_q <= data_in;
            end
          end
        end
        StSetup, StXfer: begin
          if (half_end) begin
            cnt_q <= '0;
            if (state_q == StXfer && hp_q == LastHp) begin
              state_q <= StHold;
            end else begin
              state_q <= StXfer;
              hp_q    <= hp_next;
              sclk    <= ~sclk;
              if (sample_now) begin
                rx_q <= (rx_q << 1) | DATA_W'(miso_s);
              end else begin
                mosi <= tx_q[F-1];
                tx_q <= tx_q << 1;
              end
            end
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        StHold: begin
          if (half_end) begin
            state_q  <= StDone;
            busy     <= 1'b0;
            done     <= 1'b1;
            ss_n     <= '1;
            data_out <= rx_q;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl (F=10, NUM_CS=2) with a behavioural SPI slave on ss_n[0].
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [9:0] data_in = '0;
  logic [2:0] cs_sel = '0;
  logic [7:0] clk_div = '0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       miso;
  logic [7:0] data_out;
  logic       busy, done, sclk, mosi;
  logic [1:0] ss_n;
`ifdef SPI_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  spi_master_ctrl #(
    .DATA_W(8),
    .CMD_W (2),
    .NUM_CS(2),
    .DIV_W (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data_in (data_in),
    .cs_sel  (cs_sel),
    .clk_div (clk_div),
    .cpol    (cpol),
    .cpha    (cpha),
`ifdef SPI_LOOPBACK_EN
    .loopback(loopback),
`endif
    .data_out(data_out),
    .busy    (busy),
    .done    (done),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .ss_n    (ss_n)
  );

  always #5 clk = ~clk;

  // Slave on ss_n[0]: drives its response MSB first, changing on the edge the master does not sample.
  logic       slv_en = 1'b1;
  logic       slv_cpol = 1'b0;
  logic       slv_cpha = 1'b0;
  logic [9:0] slv_data = '0;
  logic [9:0] slv_sh = '0;
  logic       slv_sclk_p = 1'b0;
  logic       slv_ss_p = 1'b1;

  always @(negedge clk) begin
    if (!slv_en) begin
      miso <= 1'b0;
    end else if (!ss_n[0] && slv_ss_p) begin
      if (!slv_cpha) begin
        miso   <= slv_data[9];
        slv_sh <= slv_data << 1;
      end else begin
        slv_sh <= slv_data;
      end
    end else if (!ss_n[0] && sclk != slv_sclk_p &&
                 (slv_cpha ? (slv_sclk_p == slv_cpol) : (sclk == slv_cpol))) begin
      miso   <= slv_sh[9];
      slv_sh <= slv_sh << 1;
    end
    slv_sclk_p <= sclk;
    slv_ss_p   <= ss_n[0];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int         done_cyc, busy_cnt, ss_low, rises;
  logic [9:0] mosi_bits;
  logic       sclk_hist [0:63];

  // Start one transfer on slave 0; cycle 0 is the accepting edge, observation stops at done.
  task automatic run_xfer(input logic p_cpol, input logic p_cpha, input logic [7:0] p_div,
                          input logic [9:0] p_data, input logic [9:0] p_resp);
    logic sclk_p;
    @(negedge clk);
    cpol = p_cpol; cpha = p_cpha; clk_div = p_div; data_in = p_data; cs_sel = 3'd0;
    slv_cpol = p_cpol; slv_cpha = p_cpha; slv_data = p_resp;
    sclk_p = sclk;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = 0; busy_cnt = 0; ss_low = 0; rises = 0; mosi_bits = '0;
    for (int c = 1; c <= 400 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (c < 64) sclk_hist[c] = sclk;
      if (busy) busy_cnt++;
      if (!ss_n[0]) ss_low++;
      if (sclk && !sclk_p && !ss_n[0]) begin
        mosi_bits = {mosi_bits[8:0], mosi};
        rises++;
      end
      sclk_p = sclk;
      if (done) done_cyc = c;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_seen, done_seen, ss_seen, cs1_low, d1, d2;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_ss_n", ss_n, 2'b11);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_sclk", sclk, 0);
    check_eq("rst_mosi", mosi, 0);
    check_eq("rst_data_out", data_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Mode 0, H=1
    run_xfer(1'b0, 1'b0, 8'd0, 10'h2A5, 10'h33C);
    check_eq("m0_done_cyc", done_cyc, 23);
    check_eq("m0_data_out", data_out, 8'h3C);
    check_eq("m0_mosi_bits", mosi_bits, 10'h2A5);
    check_eq("m0_rises", rises, 10);
    check_eq("m0_busy_cycles", busy_cnt, 22);

    // Mode 3, H=4
    run_xfer(1'b1, 1'b1, 8'd3, 10'h1FF, 10'h2C3);
    check_eq("m3_done_cyc", done_cyc, 89);
    check_eq("m3_ss_low", ss_low, 88);
    check_eq("m3_data_out", data_out, 8'hC3);
    check_eq("m3_sclk_c4", sclk_hist[4], 1);
    check_eq("m3_sclk_c5", sclk_hist[5], 0);
    check_eq("m3_sclk_c8", sclk_hist[8], 0);
    check_eq("m3_sclk_c9", sclk_hist[9], 1);
    @(negedge clk);
    check_eq("m3_sclk_idle", sclk, 1);

    // Reset in the middle of a mode-3 transfer
    cpol = 1'b1; cpha = 1'b1; clk_div = 8'd3; data_in = 10'h1FF; cs_sel = 3'd0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("mid_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_ss_n", ss_n, 2'b11);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_sclk", sclk, 0);
    check_eq("mid_data_out", data_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_xfer(1'b0, 1'b0, 8'd0, 10'h2A5, 10'h33C);
    check_eq("post_rst_done_cyc", done_cyc, 23);
    check_eq("post_rst_data_out", data_out, 8'h3C);

    // Out-of-range select is ignored
    @(negedge clk);
    cs_sel = 3'd2; cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0; start = 1'b1;
    busy_seen = 0; done_seen = 0; ss_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 3) start = 1'b0;
      if (busy) busy_seen++;
      if (done) done_seen++;
      if (ss_n != 2'b11) ss_seen++;
    end
    check_eq("badcs_busy", busy_seen, 0);
    check_eq("badcs_done", done_seen, 0);
    check_eq("badcs_ss_n", ss_seen, 0);

    // Start pulses while busy are ignored
    cs_sel = 3'd0; data_in = 10'h2A5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_seen = 0; cs1_low = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (!ss_n[1]) cs1_low++;
      start  = (c == 5 || c == 12 || c == 20);
      cs_sel = start ? 3'd1 : 3'd0;
    end
    start = 1'b0;
    check_eq("busy_start_dones", done_seen, 1);
    check_eq("busy_start_cs1", cs1_low, 0);

    // start held high: re-trigger every 24 cycles
    @(negedge clk);
    cs_sel = 3'd0; start = 1'b1;
    @(posedge clk);
    #1;
    d1 = 0; d2 = 0;
    for (int c = 1; c <= 60 && d2 == 0; c++) begin
      @(negedge clk);
      if (done) begin
        if (d1 == 0) d1 = c;
        else d2 = c;
      end
    end
    start = 1'b0;
    check_eq("b2b_first_done", d1, 23);
    check_eq("b2b_second_done", d2, 47);

`ifdef SPI_LOOPBACK_EN
    loopback = 1'b1;
    slv_en = 1'b0;
    run_xfer(1'b0, 1'b1, 8'd0, 10'h0A5, 10'h000);
    check_eq("lb_data_out", data_out, 8'hA5);
    loopback = 1'b0;
    slv_en = 1'b1;
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
